// File: rtl/sram_lsu_ctrl.sv
// Load/store controller for a single-port TCM SRAM with a 1-cycle registered read.
// It turns byte/half/word requests into masked word accesses and returns extended load data.
module sram_lsu_ctrl #(
   parameter int unsigned DP = 512,
   parameter int unsigned AW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [AW-1:0] req_addr,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [3:0]    ram_wem,
   output logic [31:0]   ram_din,
   input  logic [31:0]   ram_dout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      RSP  = 2'd2
   } state_t;

   localparam logic [AW-1:0] DP_W = AW'(DP);

   state_t       state_r;
   logic         req_ready_r;
   logic         rsp_valid_r;
   logic         rsp_err_r;
   logic [31:0]  rsp_rdata_r;
   logic [1:0]   lat_off_r;
   logic [1:0]   lat_size_r;
   logic         lat_uns_r;

   logic         accept_s;
   logic         misalign_s;
   logic         range_err_s;
   logic         req_err_s;
   logic         store_s;
   logic [3:0]   wem_s;
   logic [31:0]  din_s;

   // Pick the addressed lane(s) out of a RAM word and extend to 32 bits.
   function automatic logic [31:0] extract(input logic [31:0] dout, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = dout[{off, 3'b000} +: 8];
      h = off[1] ? dout[31:16] : dout[15:0];
      case (size)
         2'b00:   r = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
         2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
         2'b10:   r = dout;
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   // Request legality: alignment per size, illegal size, and word index range.
   always_comb begin
      misalign_s = 1'b0;
      case (req_size)
         2'b00:   misalign_s = 1'b0;
         2'b01:   misalign_s = req_addr[0];
         2'b10:   misalign_s = |req_addr[1:0];
         default: misalign_s = 1'b1;
      endcase
      range_err_s = ({2'b00, req_addr[AW-1:2]} >= DP_W);
      req_err_s   = misalign_s | range_err_s;
      accept_s    = req_valid & req_ready_r & (state_r == IDLE) & ~rst;
      store_s     = accept_s & req_write & ~req_err_s;
   end

   // Byte write mask and lane-replicated write data for the store path.
   always_comb begin
      wem_s = 4'b0000;
      din_s = req_wdata;
      case (req_size)
         2'b00: begin
            wem_s = 4'b0001 << req_addr[1:0];
            din_s = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            wem_s = req_addr[1] ? 4'b1100 : 4'b0011;
            din_s = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            wem_s = 4'b1111;
            din_s = req_wdata;
         end
         default: begin
            wem_s = 4'b0000;
            din_s = req_wdata;
         end
      endcase
   end

   assign ram_addr  = {2'b00, req_addr[AW-1:2]};
   assign ram_we    = store_s;
   assign ram_wem   = store_s ? wem_s : 4'b0000;
   assign ram_din   = din_s;
   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

   // Control FSM; the load result is captured in RD so a stalled response never relies on ram_dout.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         req_ready_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
         lat_off_r   <= 2'b00;
         lat_size_r  <= 2'b00;
         lat_uns_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               req_ready_r <= 1'b1;
               if (accept_s) begin
                  req_ready_r <= 1'b0;
                  if (req_err_s) begin
                     state_r     <= RSP;
                     rsp_valid_r <= 1'b1;
                     rsp_err_r   <= 1'b1;
                     rsp_rdata_r <= 32'h0000_0000;
                  end else if (req_write) begin
                     state_r     <= RSP;
                     rsp_valid_r <= 1'b1;
                     rsp_err_r   <= 1'b0;
                     rsp_rdata_r <= 32'h0000_0000;
                  end else begin
                     state_r    <= RD;
                     lat_off_r  <= req_addr[1:0];
                     lat_size_r <= req_size;
                     lat_uns_r  <= req_unsigned;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RD: begin
               state_r     <= RSP;
               rsp_valid_r <= 1'b1;
               rsp_err_r   <= 1'b0;
               rsp_rdata_r <= extract(ram_dout, lat_off_r, lat_size_r, lat_uns_r);
            end
            RSP: begin
               if (rsp_ready) begin
                  state_r     <= IDLE;
                  req_ready_r <= 1'b1;
                  rsp_valid_r <= 1'b0;
                  rsp_err_r   <= 1'b0;
                  rsp_rdata_r <= 32'h0000_0000;
               end else begin
                  state_r <= RSP;
               end
            end
            default: begin
               state_r     <= IDLE;
               req_ready_r <= 1'b0;
               rsp_valid_r <= 1'b0;
               rsp_err_r   <= 1'b0;
               rsp_rdata_r <= 32'h0000_0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_lsu_ctrl.sv
// Directed bench for sram_lsu_ctrl with a behavioural single-port SRAM and a side write port.
module tb_sram_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] ram_addr;
   logic        ram_we;
   logic [3:0]  ram_wem;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;

   logic        ext_we;
   logic [8:0]  ext_addr;
   logic [31:0] ext_data;
   logic [31:0] mem [0:511];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_lsu_ctrl #(.DP(512), .AW(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wem(ram_wem), .ram_din(ram_din),
      .ram_dout(ram_dout)
   );

   // SRAM model: registered read address, byte-masked write, plus a second agent's write port.
   always @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++)
            if (ram_wem[i]) mem[ram_addr[8:0]][8*i +: 8] <= ram_din[8*i +: 8];
      end else begin
         ram_dout <= mem[ram_addr[8:0]];
      end
      if (ext_we) mem[ext_addr] <= ext_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] d);
      req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz;
      req_unsigned = u; req_wdata = d;
      #1;
   endtask

   task automatic accept();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      #1;
   endtask

   task automatic run_store(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] d, input logic [3:0] wem, input logic [31:0] din);
      issue(1'b1, a, sz, 1'b0, d);
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_we"}, 32'(ram_we), 32'd1);
      chk({tag, "_wem"}, 32'(ram_wem), 32'(wem));
      chk({tag, "_din"}, ram_din, din);
      chk({tag, "_addr"}, ram_addr, a >> 2);
      accept();
      chk({tag, "_t1_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_t1_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_t1_err"}, 32'(rsp_err), 32'd0);
      chk({tag, "_t1_we"}, 32'(ram_we), 32'd0);
      cyc();
      chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   task automatic run_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic u, input logic [31:0] exp);
      issue(1'b0, a, sz, u, 32'h5A5A_5A5A);
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_we"}, 32'(ram_we), 32'd0);
      chk({tag, "_wem"}, 32'(ram_wem), 32'd0);
      chk({tag, "_addr"}, ram_addr, a >> 2);
      accept();
      chk({tag, "_t1_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_t1_ready"}, 32'(req_ready), 32'd0);
      cyc();
      chk({tag, "_t2_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_t2_rdata"}, rsp_rdata, exp);
      chk({tag, "_t2_err"}, 32'(rsp_err), 32'd0);
      cyc();
      chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
   endtask

   task automatic run_err(input string tag, input logic w, input logic [31:0] a, input logic [1:0] sz);
      issue(w, a, sz, 1'b0, 32'hFFFF_FFFF);
      chk({tag, "_we"}, 32'(ram_we), 32'd0);
      accept();
      chk({tag, "_t1_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_t1_err"}, 32'(rsp_err), 32'd1);
      chk({tag, "_t1_rdata"}, rsp_rdata, 32'd0);
      cyc();
      chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; rsp_ready = 1'b1; ext_we = 1'b0; ext_addr = 9'd0; ext_data = 32'd0;
      // A legal store held during reset must not reach the RAM.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_size = 2'b10;
      req_unsigned = 1'b0; req_wdata = 32'h1111_1111;
      cyc(); cyc();
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_wem", 32'(ram_wem), 32'd0);
      req_valid = 1'b0;
      rst = 1'b0;
      cyc();
      chk("rst_rel_ready", 32'(req_ready), 32'd1);

      // 1: word store then word load
      run_store("st_w", 32'h10, 2'b10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
      run_load("ld_w", 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF);

      // 2: byte store into lane 3, signed/unsigned reload, neighbours untouched
      run_store("st_b", 32'h13, 2'b00, 32'h0000_0080, 4'b1000, 32'h8080_8080);
      run_load("ld_bs", 32'h13, 2'b00, 1'b0, 32'hFFFF_FF80);
      run_load("ld_bu", 32'h13, 2'b00, 1'b1, 32'h0000_0080);
      run_load("ld_w2", 32'h10, 2'b10, 1'b1, 32'h80AD_BEEF);
      run_load("ld_b1", 32'h11, 2'b00, 1'b0, 32'hFFFF_FFBE);

      // 3: upper half store and reload, misaligned half
      run_store("st_h", 32'h22, 2'b01, 32'h0000_8001, 4'b1100, 32'h8001_8001);
      run_load("ld_hs", 32'h22, 2'b01, 1'b0, 32'hFFFF_8001);
      run_load("ld_hu", 32'h22, 2'b01, 1'b1, 32'h0000_8001);
      run_load("ld_hl", 32'h12, 2'b01, 1'b0, 32'hFFFF_80AD);
      run_err("err_h", 1'b0, 32'h21, 2'b01);
      run_err("err_hst", 1'b1, 32'h21, 2'b01);

      // 4: range and size errors, last in-range word
      run_err("err_rng", 1'b0, 32'h800, 2'b10);
      run_err("err_rngst", 1'b1, 32'h800, 2'b00);
      run_err("err_sz", 1'b1, 32'h10, 2'b11);
      run_err("err_wmis", 1'b0, 32'h12, 2'b10);
      run_store("st_top", 32'h7FF, 2'b00, 32'h0000_007F, 4'b1000, 32'h7F7F_7F7F);
      run_load("ld_top", 32'h7FF, 2'b00, 1'b0, 32'h0000_007F);
      run_load("ld_w3", 32'h10, 2'b10, 1'b0, 32'h80AD_BEEF);

      // 5: stalled response while RAM contents change underneath
      rsp_ready = 1'b0;
      issue(1'b0, 32'h10, 2'b10, 1'b0, 32'd0);
      accept();
      cyc();
      chk("stall_valid0", 32'(rsp_valid), 32'd1);
      chk("stall_rdata0", rsp_rdata, 32'h80AD_BEEF);
      for (int i = 0; i < 5; i++) begin
         ext_we = 1'b1; ext_addr = 9'd4; ext_data = 32'h1234_0000 + 32'(i);
         issue(1'b1, 32'h10, 2'b10, 1'b0, 32'hCAFE_F00D);
         chk("stall_we", 32'(ram_we), 32'd0);
         cyc();
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rdata", rsp_rdata, 32'h80AD_BEEF);
         chk("stall_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      ext_data = 32'h80AD_BEEF;
      rsp_ready = 1'b1;
      cyc();
      ext_we = 1'b0;
      chk("stall_rel_valid", 32'(rsp_valid), 32'd0);
      chk("stall_rel_ready", 32'(req_ready), 32'd1);

      // 6a: reset while in RD
      issue(1'b0, 32'h10, 2'b10, 1'b0, 32'd0);
      accept();
      rst = 1'b1;
      issue(1'b1, 32'h10, 2'b10, 1'b0, 32'h0BAD_0BAD);
      chk("rstrd_we", 32'(ram_we), 32'd0);
      cyc();
      chk("rstrd_valid", 32'(rsp_valid), 32'd0);
      chk("rstrd_we2", 32'(ram_we), 32'd0);
      req_valid = 1'b0;
      rst = 1'b0;
      cyc();
      chk("rstrd_ready", 32'(req_ready), 32'd1);
      chk("rstrd_valid2", 32'(rsp_valid), 32'd0);

      // 6b: reset while a response is stalled
      rsp_ready = 1'b0;
      issue(1'b1, 32'h10, 2'b10, 1'b0, 32'h80AD_BEEF);
      accept();
      cyc();
      chk("rstrsp_hold", 32'(rsp_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstrsp_we", 32'(ram_we), 32'd0);
      cyc();
      chk("rstrsp_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      rsp_ready = 1'b1;
      cyc();
      chk("rstrsp_ready", 32'(req_ready), 32'd1);
      run_load("ld_final", 32'h10, 2'b10, 1'b0, 32'h80AD_BEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
